fifo_downsizer: RTL and testbench
=================================

# fifo_downsizer

Output stage that sits directly downstream of `fifo` and converts its pop-style interface into a narrower valid/ready stream. It is driven by the FIFO's `empty_o`, `dat_o` and `flush_i` and drives the FIFO's `pop_i`. Each popped DATA_WIDTH word is held in a register and emitted as RATIO beats of OUT_WIDTH bits, least-significant beat first, at up to one beat per cycle with no bubble between words.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: FIFO word width.
- `OUT_WIDTH`, default 8: output beat width. Must divide `DATA_WIDTH` exactly.
- `RATIO`, default `DATA_WIDTH/OUT_WIDTH`: number of beats per word, at least 1.
- `LOG_RATIO`, default `(RATIO > 1) ? $clog2(RATIO) : 1`: width of the beat counter.

Ports:
- `clk_i`  in  1  Single clock.
- `rst_n_i`  in  1  Reset. Asynchronous, active-low.
- `flush_i`  in  1  Synchronous flush, shared with the FIFO's `flush_i`.
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `fifo_dat_i`  in  DATA_WIDTH  FIFO `dat_o`, the head word. Valid while `fifo_empty_i` is 0.
- `fifo_pop_o`  out  1  FIFO `pop_i`. Combinational.
- `valid_o`  out  1  Output beat valid.
- `ready_i`  in  1  Downstream ready.
- `dat_o`  out  OUT_WIDTH  Output beat.
- `last_o`  out  1  Marks the final beat of a word. Qualified by `valid_o`.
- `busy_o`  out  1  A word is held, i.e. state is SEND.

## Operation

- **States** (2-state FSM): EMPTY (no word held) and SEND (word held, `valid_o` = 1).
- **Registers:**
  - `s_word_q` [DATA_WIDTH], the held word.
  - `s_beat_q` [LOG_RATIO], the beat index.
  - `s_state_q`.
- **Beat selection:** `dat_o = s_word_q[s_beat_q*OUT_WIDTH +: OUT_WIDTH]`. `last_o = (state == SEND) && (s_beat_q == RATIO-1)`.
- **Handshake:** a beat transfers when `valid_o && ready_i`.
  - `valid_o` never depends on `ready_i`.
  - Once asserted, `valid_o`, `dat_o` and `last_o` stay stable until the beat transfers.
- **Load condition:** `load = !flush_i && !fifo_empty_i && (state == EMPTY || (hs && last_o))`.
  - `fifo_pop_o = load`.
  - On load: `s_word_q <= fifo_dat_i`, `s_beat_q <= 0`, next state SEND.
- **EMPTY:** stays in EMPTY while `fifo_empty_i` is 1. Otherwise pops and loads.
- **SEND, handshake on a non-last beat:** `s_beat_q` increments.
- **SEND, handshake on the last beat:**
  - Next word present: load it (back-to-back, no idle cycle).
  - FIFO empty: go to EMPTY with `s_beat_q` = 0.
- **SEND, no handshake:** hold all state.
- **Flush** has priority over everything:
  - Next state EMPTY, `s_beat_q` = 0.
  - `fifo_pop_o` is 0 in the flush cycle.
  - `s_word_q` is not cleared.
  - A beat handshaking in the flush cycle counts as transferred.
- **`RATIO` == 1:** acts as a single-entry registered pass-through. `last_o` = `valid_o`.
- **Beat counter width:** `LOG_RATIO` bits. It never exceeds `RATIO-1`, so no wrap handling is needed beyond the reset to 0 on the last beat.

## Timing

- **Reset values** (asynchronous, immediate on `rst_n_i` low):
  - `valid_o` = 0, `last_o` = 0, `busy_o` = 0.
  - `dat_o` = 0, since `s_word_q` resets to 0.
  - State EMPTY, `s_beat_q` = 0.
  - `fifo_pop_o` is combinational. It is 0 whenever `fifo_empty_i` or `flush_i` is 1.
- **Latency:** `fifo_empty_i` falls in cycle t (state EMPTY) → `fifo_pop_o` = 1 in cycle t → first beat has `valid_o` = 1 in cycle t+1.
- **Throughput:** with `ready_i` held at 1 and the FIFO non-empty, one beat per cycle, continuous across words. `fifo_pop_o` pulses once every RATIO cycles, in the cycle of the last-beat handshake.
- **Combinational paths:** `fifo_empty_i`, `flush_i` and `ready_i` to `fifo_pop_o`. No combinational path from `ready_i` or the FIFO inputs to `valid_o`, `dat_o` or `last_o`.
- **Reset mid-word:** the held word is discarded. FIFO contents are untouched and are the FIFO's own concern.

## Structure

- Shared package `fifo_pkg`: state typedef `ds_state_e {DS_EMPTY, DS_SEND}`.
- All flops use the existing `dffr` (async active-low reset) register cells.
- One natural sub-module: `fifo` instantiated only in the testbench, with `fifo_pop_o` wired to its `pop_i`. The RTL block itself has no sub-module.

## Test plan

All scenarios use `DATA_WIDTH`=32, `OUT_WIDTH`=8 unless stated.

1. **Single word, `ready_i`=1.** Push 0xA1B2C3D4. Expect one `fifo_pop_o` pulse, then beats 0xD4, 0xC3, 0xB2, 0xA1 on 4 consecutive cycles. `last_o` is asserted only with 0xA1. `valid_o` drops the next cycle.
2. **Back-to-back words.** Push 0x11223344 and 0x55667788, `ready_i`=1. Expect 8 contiguous beats 44,33,22,11,88,77,66,55 with no gap. The second pop coincides with the handshake of beat 0x11.
3. **Backpressure.** During beat index 1 of 0xA1B2C3D4, hold `ready_i`=0 for 3 cycles. Expect `dat_o`=0xC3 and `valid_o`=1 stable throughout, and no pop.
4. **Flush mid-word.** Assert `flush_i` for 1 cycle after beat 0xD4 transfers. Expect `valid_o`=0 the next cycle and `fifo_pop_o`=0 during flush. A word pushed afterwards restarts at beat 0.
5. **Reset mid-word.** Drop `rst_n_i` asynchronously during beat 2. Expect `valid_o`, `dat_o` and `busy_o` at 0 before the next clock edge. After release, the block is idle in EMPTY.
6. **`RATIO`=1** (`OUT_WIDTH`=32). Push 0xDEADBEEF with `ready_i` toggling 0,1. Expect a single beat 0xDEADBEEF with `last_o`=1, held until `ready_i`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO and its downsizing output stage.
// No logic of its own; holds the downsizer state encoding.
// Not applicable: package only.
package fifo_pkg;

  typedef enum logic {
    DS_EMPTY = 1'b0,
    DS_SEND  = 1'b1
  } ds_state_e;

  localparam int DS_STATE_W = 1;

endpackage

// File: rtl/dffr.sv
// Generic register cell with asynchronous active-low reset to zero.
// Latency: one cycle from d to q.
// No flow control; loads every cycle, callers hold by feeding q back.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/fifo.sv
// Generic synchronous FIFO with pop-style read port and head word on dat_o.
// Latency: a pushed word is visible at dat_o (empty_o low) one cycle later.
// Pushes are dropped while full_o is high; pops are ignored while empty_o is high.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign dat_o   = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= dat_i;
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_downsizer.sv
// Pops FIFO words and emits each as RATIO narrow beats, LS beat first, no bubbles.
// Latency: pop in the cycle empty falls, first beat valid the following cycle.
// Beats hold stable under ready_i low; the next pop waits for the last-beat handshake.
module fifo_downsizer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int RATIO      = DATA_WIDTH / OUT_WIDTH,
  parameter int LOG_RATIO  = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_dat_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_WIDTH-1:0]  dat_o,
  output logic                  last_o,
  output logic                  busy_o
);

  ds_state_e              s_state_q;
  ds_state_e              s_state_d;
  logic [DS_STATE_W-1:0]  state_raw_q;
  logic [DS_STATE_W-1:0]  state_raw_d;
  logic [DATA_WIDTH-1:0]  s_word_q;
  logic [DATA_WIDTH-1:0]  s_word_d;
  logic [LOG_RATIO-1:0]   s_beat_q;
  logic [LOG_RATIO-1:0]   s_beat_d;
  logic                   hs;
  logic                   load;

  // State register: the enum travels through the plain register cell.
  assign state_raw_d = s_state_d;
  assign s_state_q   = ds_state_e'(state_raw_q);

  dffr #(.W(DS_STATE_W)) u_state_q (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (state_raw_d),
    .q     (state_raw_q)
  );

  dffr #(.W(DATA_WIDTH)) u_word_q (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (s_word_d),
    .q     (s_word_q)
  );

  dffr #(.W(LOG_RATIO)) u_beat_q (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (s_beat_d),
    .q     (s_beat_q)
  );

  // Next state: flush wins, then a load, then beat advance on handshake.
  always_comb begin
    s_state_d = s_state_q;
    s_word_d  = s_word_q;
    s_beat_d  = s_beat_q;
    if (flush_i) begin
      // The held word is left in place; it is simply no longer valid.
      s_state_d = DS_EMPTY;
      s_beat_d  = '0;
    end else if (load) begin
      s_state_d = DS_SEND;
      s_word_d  = fifo_dat_i;
      s_beat_d  = '0;
    end else if ((s_state_q == DS_SEND) && hs) begin
      if (last_o) begin
        s_state_d = DS_EMPTY;
        s_beat_d  = '0;
      end else begin
        s_beat_d  = s_beat_q + LOG_RATIO'(1);
      end
    end
  end

  // Outputs: valid/last come from registers only; pop is the load decision.
  always_comb begin
    valid_o    = (s_state_q == DS_SEND);
    busy_o     = (s_state_q == DS_SEND);
    last_o     = (s_state_q == DS_SEND) && (s_beat_q == LOG_RATIO'(RATIO-1));
    hs         = valid_o && ready_i;
    load       = !flush_i && !fifo_empty_i &&
                 ((s_state_q == DS_EMPTY) || (hs && last_o));
    fifo_pop_o = load;
  end

  // Beat select; a single-beat configuration is a plain pass-through of the word.
  generate
    if (RATIO == 1) begin : g_pass
      assign dat_o = s_word_q[OUT_WIDTH-1:0];
    end else begin : g_split
      logic [RATIO-1:0][OUT_WIDTH-1:0] beats;
      assign beats = s_word_q;
      assign dat_o = beats[s_beat_q];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_downsizer.sv
// Bench: FIFO + downsizer (32->8) with a beat scoreboard, plus a 32->32 instance.
// Latency and corner sequences are hand-written; bulk traffic is table-driven.
// Inputs change 1ns after posedge, outputs are sampled on negedge.
module tb_fifo_downsizer;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        push;
  logic [31:0] push_dat;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] fifo_dat;
  logic        valid;
  logic        ready;
  logic [7:0]  dat;
  logic        last;
  logic        busy;

  logic        push1;
  logic [31:0] push_dat1;
  logic        fifo1_full;
  logic        fifo1_empty;
  logic        fifo1_pop;
  logic [31:0] fifo1_dat;
  logic        valid1;
  logic        ready1;
  logic [31:0] dat1;
  logic        last1;
  logic        busy1;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pop_cnt  = 0;
  logic [8:0]  exp_q [$];
  logic [8:0]  e;
  vec_t        tbl [6];

  always #5 clk = ~clk;

  fifo #(.WIDTH(32), .DEPTH(8)) u_fifo (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .push_i(push), .dat_i(push_dat),
    .full_o(fifo_full), .pop_i(fifo_pop), .dat_o(fifo_dat), .empty_o(fifo_empty)
  );

  fifo_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_dat_i(fifo_dat), .fifo_pop_o(fifo_pop), .valid_o(valid), .ready_i(ready),
    .dat_o(dat), .last_o(last), .busy_o(busy)
  );

  fifo #(.WIDTH(32), .DEPTH(2)) u_fifo1 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .push_i(push1), .dat_i(push_dat1),
    .full_o(fifo1_full), .pop_i(fifo1_pop), .dat_o(fifo1_dat), .empty_o(fifo1_empty)
  );

  fifo_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(32)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .fifo_empty_i(fifo1_empty),
    .fifo_dat_i(fifo1_dat), .fifo_pop_o(fifo1_pop), .valid_o(valid1), .ready_i(ready1),
    .dat_o(dat1), .last_o(last1), .busy_o(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every handshake on the 32->8 instance must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_pop === 1'b1) pop_cnt++;
      if (valid === 1'b1 && ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat: got beat 0x%0h, expected no beat at %0t", dat, $time);
        end else begin
          e = exp_q.pop_front();
          n_checks--;
          check("beat_dat", 64'(dat), 64'(e[7:0]));
          check("beat_last", 64'(last), 64'(e[8]));
        end
      end
    end
  end

  // Push one word into the 32->8 FIFO for one cycle and queue its expected beats.
  task automatic push_word(input vec_t v);
    push     = 1'b1;
    push_dat = v.word;
    exp_q.push_back({1'b0, v.b0});
    exp_q.push_back({1'b0, v.b1});
    exp_q.push_back({1'b0, v.b2});
    exp_q.push_back({1'b1, v.b3});
    @(posedge clk); #1;
    push = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_valid", 64'(valid), 64'(1));
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    tbl[1] = '{32'h11223344, 8'h44, 8'h33, 8'h22, 8'h11};
    tbl[2] = '{32'h55667788, 8'h88, 8'h77, 8'h66, 8'h55};
    tbl[3] = '{32'h0F1E2D3C, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    tbl[4] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[5] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};

    rst_n = 1'b1; flush = 1'b0; push = 1'b0; push_dat = '0; ready = 1'b0;
    push1 = 1'b0; push_dat1 = '0; ready1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_last", 64'(last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dat", 64'(dat), 64'(0));
    check("rst_pop", 64'(fifo_pop), 64'(0));
    check("rst_valid_r1", 64'(valid1), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word: pop in the cycle empty falls, then four contiguous beats.
    ready = 1'b1; pop_cnt = 0;
    push_word(tbl[0]);
    @(negedge clk);
    check("lat_pop", 64'(fifo_pop), 64'(1));
    check("lat_valid_low", 64'(valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_valid", 64'(valid), 64'(1));
      check("single_last", 64'(last), 64'(i == 3));
    end
    @(negedge clk);
    check("single_valid_drop", 64'(valid), 64'(0));
    check("single_busy_drop", 64'(busy), 64'(0));
    check("single_pop_cnt", 64'(pop_cnt), 64'(1));
    @(posedge clk); #1;

    // Back-to-back words: eight beats with no gap, second pop on beat 0x11.
    pop_cnt = 0;
    push_word(tbl[1]);
    push_word(tbl[2]);
    wait_valid(10);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check("b2b_valid", 64'(valid), 64'(1));
      if (i == 3) check("b2b_pop_on_last", 64'(fifo_pop), 64'(1));
      if (i == 2) check("b2b_no_early_pop", 64'(fifo_pop), 64'(0));
    end
    wait_drain(20, 1'b0);
    check("b2b_pop_cnt", 64'(pop_cnt), 64'(2));

    // Backpressure on beat 1 with another word waiting in the FIFO.
    push_word(tbl[0]);
    push_word(tbl[1]);
    wait_valid(10);
    @(posedge clk); #1 ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(valid), 64'(1));
      check("bp_dat", 64'(dat), 64'(8'hC3));
      check("bp_no_pop", 64'(fifo_pop), 64'(0));
    end
    wait_drain(40, 1'b0);

    // Flush after beat 0xD4 with a second word queued.
    push_word(tbl[0]);
    push_word(tbl[1]);
    wait_valid(10);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_no_pop", 64'(fifo_pop), 64'(0));
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_valid_low", 64'(valid), 64'(0));
    check("flush_fifo_empty", 64'(fifo_empty), 64'(1));
    exp_q.delete();
    @(posedge clk); #1;
    push_word(tbl[3]);
    wait_drain(20, 1'b0);

    // Asynchronous reset while beat 0xB2 is presented.
    push_word(tbl[0]);
    begin
      int k;
      k = 0;
      @(negedge clk);
      while (!(valid === 1'b1 && dat == 8'hB2) && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("rstmid_reach_b2", 64'(dat), 64'(8'hB2));
    end
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(valid), 64'(0));
    check("rstmid_dat", 64'(dat), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_idle_busy", 64'(busy), 64'(0));
      check("rstmid_idle_pop", 64'(fifo_pop), 64'(0));
    end
    @(posedge clk); #1;

    // Table traffic: queue all words under stall, then drain with random ready.
    ready = 1'b0; pop_cnt = 0;
    for (int i = 0; i < 6; i++) push_word(tbl[i]);
    @(negedge clk);
    check("tbl_not_full", 64'(fifo_full), 64'(0));
    wait_drain(400, 1'b1);
    check("tbl_pop_cnt", 64'(pop_cnt), 64'(6));

    // Single-beat instance: word held under ready low, last with the only beat.
    push1 = 1'b1; push_dat1 = 32'hDEADBEEF;
    @(posedge clk); #1 push1 = 1'b0;
    @(negedge clk);
    check("r1_pop", 64'(fifo1_pop), 64'(1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("r1_valid", 64'(valid1), 64'(1));
      check("r1_dat", 64'(dat1), 64'(32'hDEADBEEF));
      check("r1_last", 64'(last1), 64'(1));
    end
    @(posedge clk); #1 ready1 = 1'b1;
    @(negedge clk);
    check("r1_hs_valid", 64'(valid1), 64'(1));
    @(posedge clk); #1 ready1 = 1'b0;
    @(negedge clk);
    check("r1_after_valid", 64'(valid1), 64'(0));
    check("r1_after_busy", 64'(busy1), 64'(0));
    check("r1_fifo_full", 64'(fifo1_full), 64'(0));

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
